// File: rtl/ashl_seq_pkg.sv
// rtl/ashl_seq_pkg.sv - shared state encoding and default sizes for the shift sequencer
package ashl_seq_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/ashl_stage.sv
// rtl/ashl_stage.sv - combinational single-bit arithmetic shift left step
module ashl_stage #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y,
  output logic             c,
  output logic             v
);

  assign y = {a[WIDTH-2:0], 1'b0};
  assign c = a[WIDTH-1];
  // Sign changes when the bit moving into the MSB differs from the current MSB.
  assign v = a[WIDTH-1] ^ a[WIDTH-2];

endmodule

// File: rtl/ashl_sequencer.sv
// rtl/ashl_sequencer.sv - multi-cycle controller stepping a 1-bit ASL stage by a programmed amount
module ashl_sequencer
  import ashl_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op1,
  input  logic [CNT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_out;
  logic             r_cout;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_y;
  logic             w_c;
  logic             w_v;
  logic             w_ready;
  logic             w_accept;

  ashl_stage #(.WIDTH(WIDTH)) u_stage (
    .a (r_out),
    .y (w_y),
    .c (w_c),
    .v (w_v)
  );

  assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_accept = w_ready && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = (amount == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // A start in the done cycle chains straight into the next operation.
        if (w_accept) begin
          w_next = (amount == '0) ? ST_DONE : ST_SHIFT;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_out  <= op1;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_cnt  <= amount;
    end else if (r_state == ST_SHIFT) begin
      r_out  <= w_y;
      r_cout <= w_c;
      r_ovf  <= r_ovf | w_v;
      r_cnt  <= r_cnt - CNT_W'(1);
    end
  end

  assign busy = (r_state == ST_SHIFT);
  assign done = (r_state == ST_DONE);
  assign out  = r_out;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_ashl_sequencer.sv
// tb/tb_ashl_sequencer.sv - randomized and directed self-checking bench for ashl_sequencer
module tb_ashl_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] op1;
  logic [2:0] amount;
  logic       busy;
  logic       done;
  logic [7:0] dut_out;
  logic       cout;
  logic       ovf;

  int n_vec;
  int n_err;

  ashl_sequencer #(.WIDTH(8), .CNT_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op1    (op1),
    .amount (amount),
    .busy   (busy),
    .done   (done),
    .out    (dut_out),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shifting left by n overflows iff the top n+1 bits of the operand are not all equal.
  function automatic void ref_model(input logic [7:0] op, input logic [2:0] amt,
                                    output logic [7:0] r, output logic c, output logic v);
    logic [15:0] w;
    logic [7:0]  m;
    w = {8'h00, op} << amt;
    r = w[7:0];
    c = (amt == 3'd0) ? 1'b0 : w[8];
    m = ~(8'hFF >> (int'(amt) + 1));
    v = (amt != 3'd0) && ((op & m) != 8'h00) && ((op & m) != m);
  endfunction

  task automatic do_op(input logic [7:0] op, input logic [2:0] amt, output int lat, output int bcnt);
    @(negedge clk);
    start  = 1'b1;
    op1    = op;
    amount = amt;
    @(posedge clk);
    #1;
    start  = 1'b0;
    op1    = 8'($urandom);
    amount = 3'($urandom);
    lat    = 0;
    bcnt   = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_vec++;
    if ({dut_out, cout, ovf, busy, done} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_state got %h want 000", {dut_out, cout, ovf, busy, done});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_idle busy/done got %b want 00", {busy, done});
    end
  endtask

  task automatic test_directed();
    logic [7:0] t_op [5]  = '{8'h0F, 8'h0F, 8'h81, 8'h01, 8'h5A};
    logic [2:0] t_amt [5] = '{3'd1, 3'd4, 3'd1, 3'd7, 3'd0};
    logic [9:0] t_exp [5] = '{{8'h1E, 2'b00}, {8'hF0, 2'b01}, {8'h02, 2'b11},
                              {8'h80, 2'b01}, {8'h5A, 2'b00}};
    int lat, bcnt;
    for (int i = 0; i < 5; i++) begin
      do_op(t_op[i], t_amt[i], lat, bcnt);
      n_vec++;
      if (lat !== int'(t_amt[i]) || bcnt !== int'(t_amt[i])) begin
        n_err++;
        $display("FAIL directed_timing[%0d] latency %0d busy %0d want %0d", i, lat, bcnt, t_amt[i]);
      end
      n_vec++;
      if ({dut_out, cout, ovf} !== t_exp[i]) begin
        n_err++;
        $display("FAIL directed_result[%0d] got %h want %h", i, {dut_out, cout, ovf}, t_exp[i]);
      end
    end
    @(posedge clk);
    #1;
    n_vec++;
    if ({done, dut_out, cout, ovf} !== {1'b0, t_exp[4]}) begin
      n_err++;
      $display("FAIL done_one_cycle_hold got %h want %h", {done, dut_out, cout, ovf}, {1'b0, t_exp[4]});
    end
  endtask

  task automatic test_ignore_start_and_back_to_back();
    int w, lat, bcnt;
    @(negedge clk);
    start = 1'b1; op1 = 8'h03; amount = 3'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op1 = 8'hFF; amount = 3'd7;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!done && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    n_vec++;
    if (w !== 2) begin
      n_err++;
      $display("FAIL ignore_start_latency got %0d want 2", w);
    end
    n_vec++;
    if ({dut_out, cout, ovf} !== {8'h18, 2'b00}) begin
      n_err++;
      $display("FAIL ignore_start_result got %h want %h", {dut_out, cout, ovf}, {8'h18, 2'b00});
    end
    do_op(8'h40, 3'd1, lat, bcnt);
    n_vec++;
    if (lat !== 1 || {dut_out, cout, ovf} !== {8'h80, 2'b01}) begin
      n_err++;
      $display("FAIL back_to_back latency %0d result %h want 1 %h", lat, {dut_out, cout, ovf}, {8'h80, 2'b01});
    end
  endtask

  task automatic test_async_reset();
    logic       seen;
    logic [7:0] r;
    logic       c, v;
    int         lat, bcnt;
    @(negedge clk);
    start = 1'b1; op1 = 8'h0F; amount = 3'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({dut_out, cout, ovf, busy, done} !== 12'h000) begin
      n_err++;
      $display("FAIL async_reset_clear got %h want 000", {dut_out, cout, ovf, busy, done});
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      seen = seen | done | busy;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_no_done got %b want 0", seen);
    end
    ref_model(8'h0F, 3'd5, r, c, v);
    do_op(8'h0F, 3'd5, lat, bcnt);
    n_vec++;
    if (lat !== 5 || {dut_out, cout, ovf} !== {r, c, v}) begin
      n_err++;
      $display("FAIL after_reset_op latency %0d result %h want 5 %h", lat, {dut_out, cout, ovf}, {r, c, v});
    end
  endtask

  task automatic test_random();
    logic [7:0] op, r;
    logic [2:0] amt;
    logic       c, v;
    int         lat, bcnt;
    for (int i = 0; i < 40; i++) begin
      op  = 8'($urandom);
      amt = 3'($urandom);
      ref_model(op, amt, r, c, v);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_op(op, amt, lat, bcnt);
      n_vec++;
      if (lat !== int'(amt) || bcnt !== int'(amt)) begin
        n_err++;
        $display("FAIL random_timing[%0d] op %h amt %0d latency %0d busy %0d", i, op, amt, lat, bcnt);
      end
      n_vec++;
      if ({dut_out, cout, ovf} !== {r, c, v}) begin
        n_err++;
        $display("FAIL random_result[%0d] op %h amt %0d got %h want %h", i, op, amt, {dut_out, cout, ovf}, {r, c, v});
      end
    end
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    start  = 1'b0;
    op1    = 8'h00;
    amount = 3'd0;
    rst    = 1'b1;
    test_reset();
    test_directed();
    test_ignore_start_and_back_to_back();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
